// File: rtl/boot_pkg.sv
// Shared boot-loader definitions: FSM states and UART timing helpers.
package boot_pkg;

  // Loader frame states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } boot_state_t;

  // One UART character: start + 8 data + stop
  localparam int unsigned BITS_PER_CHAR = 32'd10;

  // Clock cycles per UART bit, shared with the receiver's bit timing
  function automatic int unsigned cycles_per_symbol(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/boot_timeout_counter.sv
// Reloadable down-counter that flags the step from 1 to 0 as an expiry.
module boot_timeout_counter #(
  parameter int unsigned RELOAD = 32'd69440
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);
  localparam int unsigned CW = $clog2(RELOAD) + 1;
  localparam logic [CW-1:0] c_reload = CW'(RELOAD);

  logic [CW-1:0] r_count;

  // Load on activity, count down while idle, park at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_reload;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Expiry is the decrement that reaches zero; a load in that cycle wins
  assign o_expire = i_dec && !i_load && (r_count == CW'(1));

endmodule

// File: rtl/boot_word_loader.sv
// Parses a length-prefixed UART boot image into 32-bit memory writes.
module boot_word_loader
  import boot_pkg::*;
#(
  parameter int unsigned clk_frequency = 32'd50000000,
  parameter int unsigned baud_rate     = 32'd115200,
  parameter int unsigned addr_width    = 32'd16,
  parameter int unsigned base_addr     = 32'd0,
  parameter int unsigned timeout_chars = 32'd16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [addr_width-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error_timeout,
  output logic                  error_overflow,
  output logic                  error_size
);
  localparam int unsigned IW = addr_width - 2;
  localparam int unsigned c_reload =
    cycles_per_symbol(clk_frequency, baud_rate) * BITS_PER_CHAR * timeout_chars;
  localparam logic [32:0] c_max_words =
    33'((64'd1 << IW) - 64'(base_addr / 32'd4));
  localparam logic [addr_width-1:0] c_base = addr_width'(base_addr);

  boot_state_t r_state, w_state_nxt;
  logic [1:0]            r_lane;
  logic [23:0]           r_asm;
  logic [IW-1:0]         r_index, r_last_idx;
  logic                  r_mem_we;
  logic [addr_width-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_busy, r_done, r_error_timeout, r_error_overflow, r_error_size;

  logic        w_busy_nxt, w_done_nxt, w_tout_nxt, w_size_nxt, w_frame_start;
  logic [31:0] w_full;
  logic        w_hs, w_word_done, w_load, w_last, w_expire, w_tmr_load, w_tmr_dec;

  // The 4th byte completes either the count or a data word
  assign w_full      = {byte_data, r_asm};
  assign w_hs        = r_mem_we && mem_ready;
  assign w_word_done = (r_state == DATA) && byte_valid && (r_lane == 2'd3);
  assign w_load      = w_word_done && (!r_mem_we || w_hs);
  assign w_last      = (r_index == r_last_idx);
  assign w_tmr_load  = byte_valid && (r_state != DRAIN);
  assign w_tmr_dec   = ((r_state == COUNT) || (r_state == DATA)) && !byte_valid;

  boot_timeout_counter #(.RELOAD(c_reload)) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_load   (w_tmr_load),
    .i_dec    (w_tmr_dec),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and status strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_tout_nxt    = 1'b0;
    w_size_nxt    = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (byte_valid) begin
          w_state_nxt   = COUNT;
          w_busy_nxt    = 1'b1;
          w_frame_start = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      COUNT: begin
        if (byte_valid && (r_lane == 2'd3)) begin
          if (w_full == 32'd0) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if ({1'b0, w_full} > c_max_words) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_size_nxt  = 1'b1;
          end else begin
            w_state_nxt = DATA;
          end
        end else if (w_expire) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_tout_nxt  = 1'b1;
        end else begin
          w_state_nxt = COUNT;
        end
      end
      DATA: begin
        if (w_word_done && w_last) begin
          w_state_nxt = DRAIN;
        end else if (w_expire) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_tout_nxt  = 1'b1;
        end else begin
          w_state_nxt = DATA;
        end
      end
      DRAIN: begin
        // A dropped final word leaves only the earlier pending write to finish
        if (!r_mem_we || w_hs) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Byte lanes, count/word assembly and word index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane     <= 2'd0;
      r_asm      <= 24'd0;
      r_index    <= '0;
      r_last_idx <= '0;
    end else if (byte_valid && (r_state == IDLE)) begin
      r_asm  <= {16'd0, byte_data};
      r_lane <= 2'd1;
    end else if (byte_valid && ((r_state == COUNT) || (r_state == DATA))) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_asm[7:0]   <= byte_data;
        2'd1:    r_asm[15:8]  <= byte_data;
        2'd2:    r_asm[23:16] <= byte_data;
        default: r_asm        <= r_asm;
      endcase
      if (r_lane == 2'd3) begin
        if (r_state == COUNT) begin
          r_index    <= '0;
          r_last_idx <= w_full[IW-1:0] - IW'(1);
        end else begin
          r_index <= r_index + IW'(1);
        end
      end
    end
  end

  // Write port: load a finished word, hold while stalled, drop after handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else if (w_load) begin
      r_mem_we    <= 1'b1;
      r_mem_addr  <= c_base + {r_index, 2'b00};
      r_mem_wdata <= w_full;
    end else if (w_hs) begin
      r_mem_we <= 1'b0;
    end
  end

  // Status outputs and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_error_timeout  <= 1'b0;
      r_error_size     <= 1'b0;
      r_error_overflow <= 1'b0;
    end else begin
      r_busy          <= w_busy_nxt;
      r_done          <= w_done_nxt;
      r_error_timeout <= w_tout_nxt;
      r_error_size    <= w_size_nxt;
      if (w_frame_start) begin
        r_error_overflow <= 1'b0;
      end else if (w_word_done && !w_load) begin
        r_error_overflow <= 1'b1;
      end
    end
  end

  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error_timeout  = r_error_timeout;
  assign error_overflow = r_error_overflow;
  assign error_size     = r_error_size;

endmodule

// File: tb/tb_boot_word_loader.sv
// Directed self-checking bench for boot_word_loader.
module tb_boot_word_loader;
  // 4 clocks per UART bit, so the idle timeout is 4*10*16 = 640 cycles
  localparam int unsigned CLK_HZ = 32'd460800;
  localparam int RELOAD = 640;

  logic clk = 1'b0, reset_n = 1'b0, reset_n_b = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic mem_ready = 1'b0, mem_ready_b = 1'b1;

  logic mem_we, busy, done, error_timeout, error_overflow, error_size;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_we_b, busy_b, done_b, error_timeout_b, error_overflow_b, error_size_b;
  logic [7:0] mem_addr_b;
  logic [31:0] mem_wdata_b;

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0;
  logic [47:0] hs_q[$];

  always #5 clk = ~clk;

  boot_word_loader #(.clk_frequency(CLK_HZ), .baud_rate(32'd115200), .addr_width(32'd16),
                     .base_addr(32'd0), .timeout_chars(32'd16)) dut (
    .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error_timeout(error_timeout),
    .error_overflow(error_overflow), .error_size(error_size));

  boot_word_loader #(.clk_frequency(CLK_HZ), .baud_rate(32'd115200), .addr_width(32'd8),
                     .base_addr(32'd0), .timeout_chars(32'd16)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .byte_valid(byte_valid), .byte_data(byte_data),
    .mem_we(mem_we_b), .mem_ready(mem_ready_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .busy(busy_b), .done(done_b), .error_timeout(error_timeout_b),
    .error_overflow(error_overflow_b), .error_size(error_size_b));

  // Record every write handshake and done pulse of the main instance
  always @(posedge clk) begin
    if (reset_n && mem_we && mem_ready) hs_q.push_back({mem_addr, mem_wdata});
    if (reset_n && done) done_cnt = done_cnt + 1;
  end

  // Called at a negedge; byte is sampled on the following posedge
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({mem_we, busy, done, error_timeout, error_overflow, error_size} !== 6'b0) begin n_err++; $display("FAIL reset_outputs got=%b want=000000", {mem_we, busy, done, error_timeout, error_overflow, error_size}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 48'd0) begin n_err++; $display("FAIL reset_bus got=%h want=0", {mem_addr, mem_wdata}); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_two_words();
    int d0, h0;
    d0 = done_cnt; h0 = hs_q.size();
    mem_ready = 1'b1;
    send_byte(8'h02);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tw_busy_rise got=%b want=1", busy); end
    idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    send_byte(8'h78); idle(1); send_byte(8'h56); idle(1); send_byte(8'h34); idle(1);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL tw_we_early got=%b want=0", mem_we); end
    send_byte(8'h12);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 32'h12345678}) begin n_err++; $display("FAIL tw_word1 got=%h want=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0000, 32'h12345678}); end
    idle(1);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL tw_we_drop got=%b want=0", mem_we); end
    send_byte(8'hEF); idle(1); send_byte(8'hBE); idle(1); send_byte(8'hAD); idle(1); send_byte(8'hDE);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0004, 32'hDEADBEEF}) begin n_err++; $display("FAIL tw_word2 got=%h want=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0004, 32'hDEADBEEF}); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL tw_done_early got=%b want=0", done); end
    idle(1);
    n_cmp++; if ({done, busy, mem_we} !== 3'b100) begin n_err++; $display("FAIL tw_done got=%b want=100", {done, busy, mem_we}); end
    idle(3);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL tw_done_count got=%0d want=1", done_cnt - d0); end
    n_cmp++; if (hs_q.size() - h0 !== 2) begin n_err++; $display("FAIL tw_hs_count got=%0d want=2", hs_q.size() - h0); end
    else begin
      n_cmp++; if (hs_q[h0] !== {16'h0000, 32'h12345678}) begin n_err++; $display("FAIL tw_hs0 got=%h want=000012345678", hs_q[h0]); end
      n_cmp++; if (hs_q[h0+1] !== {16'h0004, 32'hDEADBEEF}) begin n_err++; $display("FAIL tw_hs1 got=%h want=0004deadbeef", hs_q[h0+1]); end
    end
  endtask

  task automatic test_zero_count();
    int h0;
    h0 = hs_q.size();
    send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL zc_busy got=%b want=10", {busy, done}); end
    send_byte(8'h00);
    n_cmp++; if ({busy, done, mem_we} !== 3'b010) begin n_err++; $display("FAIL zc_done got=%b want=010", {busy, done, mem_we}); end
    idle(1);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zc_done_pulse got=%b want=0", done); end
    idle(2);
    n_cmp++; if (hs_q.size() !== h0) begin n_err++; $display("FAIL zc_no_write got=%0d want=%0d", hs_q.size(), h0); end
  endtask

  task automatic test_overflow();
    int h0;
    h0 = hs_q.size();
    mem_ready = 1'b0;
    send_byte(8'h02); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    send_byte(8'h78); idle(1); send_byte(8'h56); idle(1); send_byte(8'h34); idle(1); send_byte(8'h12);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 32'h12345678}) begin n_err++; $display("FAIL ov_word1 got=%h want=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0000, 32'h12345678}); end
    idle(3);
    send_byte(8'hEF); idle(1); send_byte(8'hBE); idle(1); send_byte(8'hAD); idle(1); send_byte(8'hDE);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 32'h12345678}) begin n_err++; $display("FAIL ov_hold got=%h want=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0000, 32'h12345678}); end
    n_cmp++; if ({error_overflow, busy, done} !== 3'b110) begin n_err++; $display("FAIL ov_flag got=%b want=110", {error_overflow, busy, done}); end
    idle(2);
    mem_ready = 1'b1;
    idle(1);
    n_cmp++; if ({done, busy, mem_we, error_overflow} !== 4'b1001) begin n_err++; $display("FAIL ov_release got=%b want=1001", {done, busy, mem_we, error_overflow}); end
    idle(2);
    n_cmp++; if (hs_q.size() - h0 !== 1) begin n_err++; $display("FAIL ov_hs_count got=%0d want=1", hs_q.size() - h0); end
    else begin
      n_cmp++; if (hs_q[h0] !== {16'h0000, 32'h12345678}) begin n_err++; $display("FAIL ov_hs0 got=%h want=000012345678", hs_q[h0]); end
    end
  endtask

  task automatic test_timeout();
    send_byte(8'h03);
    n_cmp++; if (error_overflow !== 1'b0) begin n_err++; $display("FAIL to_ovf_clear got=%b want=0", error_overflow); end
    idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    send_byte(8'hAA);
    idle(RELOAD - 1);
    n_cmp++; if ({error_timeout, busy} !== 2'b01) begin n_err++; $display("FAIL to_early got=%b want=01", {error_timeout, busy}); end
    idle(1);
    n_cmp++; if ({error_timeout, busy} !== 2'b10) begin n_err++; $display("FAIL to_pulse got=%b want=10", {error_timeout, busy}); end
    idle(1);
    n_cmp++; if (error_timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_len got=%b want=0", error_timeout); end
    send_byte(8'h01); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    send_byte(8'hDD); idle(1); send_byte(8'hCC); idle(1); send_byte(8'hBB); idle(1); send_byte(8'hAA);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 32'hAABBCCDD}) begin n_err++; $display("FAIL to_reload got=%h want=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0000, 32'hAABBCCDD}); end
    idle(1);
    n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL to_reload_done got=%b want=10", {done, busy}); end
    idle(2);
  endtask

  task automatic test_size();
    reset_n   = 1'b0;
    reset_n_b = 1'b1;
    idle(2);
    send_byte(8'h41); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00);
    n_cmp++; if ({error_size_b, busy_b, mem_we_b} !== 3'b100) begin n_err++; $display("FAIL sz_pulse got=%b want=100", {error_size_b, busy_b, mem_we_b}); end
    idle(1);
    n_cmp++; if (error_size_b !== 1'b0) begin n_err++; $display("FAIL sz_pulse_len got=%b want=0", error_size_b); end
    send_byte(8'h40); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00);
    n_cmp++; if ({error_size_b, busy_b} !== 2'b01) begin n_err++; $display("FAIL sz_limit got=%b want=01", {error_size_b, busy_b}); end
    reset_n_b = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid_frame();
    int h0;
    mem_ready = 1'b0;
    send_byte(8'h01); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    send_byte(8'h11); idle(1); send_byte(8'h22); idle(1); send_byte(8'h33); idle(1); send_byte(8'h44);
    n_cmp++; if ({mem_we, mem_wdata} !== {1'b1, 32'h44332211}) begin n_err++; $display("FAIL rm_pending got=%h want=%h", {mem_we, mem_wdata}, {1'b1, 32'h44332211}); end
    idle(1);
    h0 = hs_q.size();
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_we, busy, done, error_timeout, error_overflow, error_size, mem_addr, mem_wdata} !== 54'd0) begin n_err++; $display("FAIL rm_async got=%h want=0", {mem_we, busy, done, error_timeout, error_overflow, error_size, mem_addr, mem_wdata}); end
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    idle(1);
    send_byte(8'h01); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
    send_byte(8'h78); idle(1); send_byte(8'h56); idle(1); send_byte(8'h34); idle(1); send_byte(8'h12);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 32'h12345678}) begin n_err++; $display("FAIL rm_after got=%h want=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0000, 32'h12345678}); end
    idle(1);
    n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL rm_done got=%b want=10", {done, busy}); end
    idle(2);
    n_cmp++; if (hs_q.size() - h0 !== 1) begin n_err++; $display("FAIL rm_hs_count got=%0d want=1", hs_q.size() - h0); end
    else begin
      n_cmp++; if (hs_q[h0] !== {16'h0000, 32'h12345678}) begin n_err++; $display("FAIL rm_hs0 got=%h want=000012345678", hs_q[h0]); end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_overflow();
    test_timeout();
    test_size();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
